// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM with byte-lane steering,
// load extension, error checks and programmable wait states.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic        wr_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  size_q;

  logic        wr_c, uns_c;
  logic [31:0] addr_c, wdata_c;
  logic [3:0]  size_c;

  logic        accept, enter_resp;
  logic        size_ok, misal, range_err, err_c;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wsh, word, rsh, ld;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign accept      = req_valid_i && req_ready_o;

  // With zero wait states the SRAM is accessed on the accepting
  // edge itself, so the live request is used while in IDLE.
  assign wr_c    = (state == IDLE) ? req_write_i    : wr_q;
  assign uns_c   = (state == IDLE) ? req_unsigned_i : uns_q;
  assign addr_c  = (state == IDLE) ? req_addr_i     : addr_q;
  assign wdata_c = (state == IDLE) ? req_wdata_i    : wdata_q;
  assign size_c  = (state == IDLE) ? req_size_i     : size_q;

  assign off = addr_c[1:0];
  assign idx = addr_c[AW+1:2];
  assign be  = size_c << off;
  assign wsh = wdata_c << {off, 3'b000};

  assign size_ok   = (size_c == 4'b0001) ||
                     (size_c == 4'b0011) ||
                     (size_c == 4'b1111);
  assign misal     = ((size_c == 4'b0011) && off[0]) ||
                     ((size_c == 4'b1111) && (off != 2'b00));
  assign range_err = ({2'b00, addr_c[31:2]} >= 32'(DEPTH));
  assign err_c     = !size_ok || misal || range_err;

  assign word = mem[idx];
  assign rsh  = word >> {off, 3'b000};

  always_comb begin
    ld = rsh;
    unique case (1'b1)
      size_c == 4'b0001:
        ld = uns_c ? {24'b0, rsh[7:0]}
                   : {{24{rsh[7]}}, rsh[7:0]};
      size_c == 4'b0011:
        ld = uns_c ? {16'b0, rsh[15:0]}
                   : {{16{rsh[15]}}, rsh[15:0]};
      default: ld = rsh;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)
              state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wr_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 4'd0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_write_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err_o   <= err_c;
        rsp_rdata_o <= (err_c || wr_c) ? 32'd0 : ld;
      end else if ((state == RESP) && rsp_ready_i) begin
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= 32'd0;
      end
    end
  end

  // SRAM is not reset; a write is only committed outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && enter_resp && wr_c && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait
// state and one with none.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v1, v0;
  logic        req_write, uns, rsp_ready;
  logic [31:0] addr, wdata;
  logic [3:0]  size;

  logic        rr1, rv1, re1;
  logic [31:0] rd1;
  logic        rr0, rv0, re0;
  logic [31:0] rd0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(1)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (v1),
    .req_ready_o    (rr1),
    .req_write_i    (req_write),
    .req_addr_i     (addr),
    .req_size_i     (size),
    .req_unsigned_i (uns),
    .req_wdata_i    (wdata),
    .rsp_valid_o    (rv1),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rd1),
    .rsp_err_o      (re1)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (v0),
    .req_ready_o    (rr0),
    .req_write_i    (req_write),
    .req_addr_i     (addr),
    .req_size_i     (size),
    .req_unsigned_i (uns),
    .req_wdata_i    (wdata),
    .rsp_valid_o    (rv0),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rd0),
    .rsp_err_o      (re0)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input bit ws0,
                      input logic w,
                      input logic [31:0] a,
                      input logic [3:0] s,
                      input logic u,
                      input logic [31:0] d,
                      output logic [31:0] rd,
                      output logic e,
                      output int lat);
    @(negedge clk);
    req_write = w;
    addr      = a;
    size      = s;
    uns       = u;
    wdata     = d;
    if (ws0) v0 = 1'b1;
    else     v1 = 1'b1;
    @(posedge clk);
    #1;
    v0  = 1'b0;
    v1  = 1'b0;
    lat = 1;
    while (!(ws0 ? rv0 : rv1) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_timeout", 32'(ws0 ? rv0 : rv1), 32'd1);
    rd = ws0 ? rd0 : rd1;
    e  = ws0 ? re0 : re1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          n;

  initial begin
    rst_n     = 1'b0;
    v1        = 1'b0;
    v0        = 1'b0;
    req_write = 1'b0;
    uns       = 1'b0;
    rsp_ready = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    size      = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(rr1), 32'd1);
    check("rst_valid", 32'(rv1), 32'd0);
    check("rst_rdata", rd1, 32'd0);
    check("rst_err",   32'(re1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(rr1), 32'd1);

    xact(0, 1, 32'h100, 4'hF, 0, 32'hDEADBEEF, rd, e, lat);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", 32'(e), 32'd0);
    xact(0, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(e), 32'd0);
    check("lw_lat", 32'(lat), 32'd2);

    xact(0, 1, 32'h100, 4'hF, 0, 32'h0, rd, e, lat);
    xact(0, 1, 32'h102, 4'h1, 0, 32'h80, rd, e, lat);
    check("sb_err", 32'(e), 32'd0);
    xact(0, 0, 32'h102, 4'h1, 0, 32'd0, rd, e, lat);
    check("lb", rd, 32'hFFFFFF80);
    xact(0, 0, 32'h102, 4'h1, 1, 32'd0, rd, e, lat);
    check("lbu", rd, 32'h00000080);
    xact(0, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("lw_after_sb", rd, 32'h00800000);

    xact(0, 1, 32'h101, 4'h3, 0, 32'hBEEF, rd, e, lat);
    check("sh_mis_err", 32'(e), 32'd1);
    xact(0, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("lw_unchanged", rd, 32'h00800000);
    xact(0, 0, 32'h102, 4'hF, 0, 32'd0, rd, e, lat);
    check("lw_mis_err", 32'(e), 32'd1);
    check("lw_mis_rdata", rd, 32'd0);

    xact(0, 1, 32'h104, 4'hF, 0, 32'h11223344, rd, e, lat);
    xact(0, 1, 32'h106, 4'h3, 0, 32'hBEEF, rd, e, lat);
    xact(0, 0, 32'h104, 4'hF, 0, 32'd0, rd, e, lat);
    check("lw_after_sh", rd, 32'hBEEF3344);
    xact(0, 0, 32'h106, 4'h3, 0, 32'd0, rd, e, lat);
    check("lh", rd, 32'hFFFFBEEF);
    xact(0, 0, 32'h106, 4'h3, 1, 32'd0, rd, e, lat);
    check("lhu", rd, 32'h0000BEEF);
    xact(0, 0, 32'h105, 4'h1, 0, 32'd0, rd, e, lat);
    check("lb_pos", rd, 32'h00000033);

    xact(0, 0, 32'h1000, 4'hF, 0, 32'd0, rd, e, lat);
    check("range_err", 32'(e), 32'd1);
    check("range_rdata", rd, 32'd0);
    xact(0, 1, 32'h1000, 4'hF, 0, 32'hFFFFFFFF, rd, e, lat);
    check("range_sw_err", 32'(e), 32'd1);
    xact(0, 1, 32'h100, 4'h7, 0, 32'hFFFFFFFF, rd, e, lat);
    check("size_err", 32'(e), 32'd1);
    xact(0, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("no_change", rd, 32'h00800000);
    xact(0, 1, 32'hFFC, 4'hF, 0, 32'hCAFEF00D, rd, e, lat);
    check("last_sw_err", 32'(e), 32'd0);
    xact(0, 0, 32'hFFC, 4'hF, 0, 32'd0, rd, e, lat);
    check("last_lw", rd, 32'hCAFEF00D);

    // Response back-pressure with a second request waiting
    @(negedge clk);
    req_write = 1'b0;
    addr      = 32'h104;
    size      = 4'hF;
    uns       = 1'b0;
    v1        = 1'b1;
    @(posedge clk);
    #1;
    addr = 32'h100;
    n    = 0;
    while (!rv1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_enter", 32'(rv1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(rv1), 32'd1);
      check("hold_rdata", rd1, 32'hBEEF3344);
      check("hold_err",   32'(re1), 32'd0);
      check("hold_ready", 32'(rr1), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("taken_valid", 32'(rv1), 32'd0);
    check("taken_ready", 32'(rr1), 32'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    check("second_accept", 32'(rr1), 32'd0);
    n = 0;
    while (!rv1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("second_rdata", rd1, 32'h00800000);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset while a store is waiting
    @(negedge clk);
    req_write = 1'b1;
    addr      = 32'h100;
    size      = 4'hF;
    wdata     = 32'h55555555;
    v1        = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    check("pre_rst_ready", 32'(rr1), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rv1), 32'd0);
    check("mid_rst_ready", 32'(rr1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(rr1), 32'd1);
    check("rel_valid", 32'(rv1), 32'd0);
    xact(0, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("old_data", rd, 32'h00800000);

    // Zero wait states
    xact(1, 1, 32'h100, 4'hF, 0, 32'hDEADBEEF, rd, e, lat);
    check("ws0_sw_lat", 32'(lat), 32'd1);
    xact(1, 0, 32'h100, 4'hF, 0, 32'd0, rd, e, lat);
    check("ws0_lw_rdata", rd, 32'hDEADBEEF);
    check("ws0_lw_lat", 32'(lat), 32'd1);
    xact(1, 0, 32'h103, 4'h1, 0, 32'd0, rd, e, lat);
    check("ws0_lb", rd, 32'hFFFFFFDE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
